// File: rtl/version_arb_pkg.sv
// Shared definitions for the version_storage read arbiters: FSM encoding,
// default storage widths and requester-count limits.
package version_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int VER_ADDR_W = 3;
    localparam int VER_DATA_W = 17;
    localparam int MAX_REQ    = 4;
    localparam int GRANT_W    = $clog2(MAX_REQ);
    localparam int LAT_W      = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: returns the first requester at or after
// rr_ptr in rotation order, plus a flag saying whether anyone is requesting.
module rr_priority_pick
    import version_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] winner,
    output logic               any
);

    // Scan from the farthest offset down so the nearest requester overrides.
    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        winner = '0;
        any    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (j == (int'(rr_ptr) + i) % NUM_REQ)) begin
                    winner = GRANT_W'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/version_read_arbiter.sv
// Round-robin arbiter serialising reads from several requesters onto the single
// registered read port of version_storage, with a one-cycle ack per read.
module version_read_arbiter
    import version_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = VER_ADDR_W,
    parameter int DATA_W  = VER_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      activity
);

    arb_state_t         state, state_nxt;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] winner;
    logic               any_req;
    logic [LAT_W-1:0]   lat_cnt;
    logic [ADDR_W-1:0]  win_addr;
    logic               lat_done;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Storage samples mem_addr one edge after we register it, so the count runs
    // down to zero: data is captured RD_LAT+1 edges after the grant edge.
    assign lat_done = (lat_cnt == '0);

    always_comb begin
        win_addr = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == GRANT_W'(j)) win_addr = req_addr[j*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = WAIT;
            WAIT:    if (lat_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            lat_cnt  <= '0;
            mem_addr <= '0;
            rd_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (any_req) begin
                    grant_id <= winner;
                    mem_addr <= win_addr;
                    lat_cnt  <= LAT_W'(RD_LAT);
                    rr_ptr   <= (winner == GRANT_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
                WAIT: begin
                    if (lat_done) rd_data <= mem_data;
                    else          lat_cnt <= lat_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            ack[j] = (state == ACK) && (grant_id == GRANT_W'(j));
        end
    end

    assign busy     = (state != IDLE);
    assign activity = |ack;

endmodule

// File: tb/tb_version_read_arbiter.sv
// Directed bench for version_read_arbiter: a RD_LAT=1 instance for arbitration
// and corner cases, and a RD_LAT=3 instance for the latency/address sweep.
module tb_version_read_arbiter;

    localparam int AW = 3;
    localparam int DW = 17;
    localparam int NR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_a, ack_a, req_b, ack_b;
    logic [NR*AW-1:0] req_addr_a, req_addr_b;
    logic [DW-1:0]    rd_data_a, mem_data_a, rd_data_b, mem_data_b;
    logic [1:0]       grant_id_a, grant_id_b;
    logic             busy_a, activity_a, busy_b, activity_b;
    logic [AW-1:0]    mem_addr_a, mem_addr_b;
    logic [DW-1:0]    pipe_b [3];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    exp_ack;
        logic [1:0]    exp_gid;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs [7];

    int            lat, busy_cnt, ack_cyc, n_ack, last_cyc, cyc, ack1_cnt, ack0_cnt;
    logic [1:0]    g_ack, g_gid, pend, r;
    logic [DW-1:0] g_data;
    logic          g_act;
    logic [AW-1:0] av;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {14'h0, 3'b101} ^ {DW{a[0]}};
    endfunction

    always_ff @(posedge clk) mem_data_a <= mem_fn(mem_addr_a);

    always_ff @(posedge clk) begin
        pipe_b[0] <= mem_fn(mem_addr_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_data_b = pipe_b[2];

    version_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_addr(req_addr_a), .ack(ack_a),
        .rd_data(rd_data_a), .grant_id(grant_id_a), .busy(busy_a), .mem_addr(mem_addr_a),
        .mem_data(mem_data_a), .activity(activity_a)
    );

    version_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_addr(req_addr_b), .ack(ack_b),
        .rd_data(rd_data_b), .grant_id(grant_id_b), .busy(busy_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .activity(activity_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else             n_pass++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called #1 after an edge with the arbiter idle; returns #1 after the edge
    // that ends the ack cycle. Latency counts edges from the request edge (=1).
    task automatic run_txn(input int sel, input logic [1:0] rq, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, output int l, output logic [1:0] ak,
                           output logic [1:0] gid, output logic [DW-1:0] data, output logic act);
        l = 0; ak = '0; gid = '0; data = '0; act = 1'b0;
        if (sel == 1) begin req_b = rq; req_addr_b = {a1, a0}; end
        else          begin req_a = rq; req_addr_a = {a1, a0}; end
        while (l < 20 && ak == '0) begin
            @(posedge clk); #1;
            l++;
            ak   = (sel == 1) ? ack_b      : ack_a;
            gid  = (sel == 1) ? grant_id_b : grant_id_a;
            data = (sel == 1) ? rd_data_b  : rd_data_a;
            act  = (sel == 1) ? activity_b : activity_a;
        end
        if (sel == 1) req_b = '0;
        else          req_a = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_a = '0; req_addr_a = '0;
        req_b = '0; req_addr_b = '0;

        vecs[0] = '{req: 2'b10, a0: 3'd0, a1: 3'd7, exp_ack: 2'b10, exp_gid: 2'd1, exp_data: 17'h1FFFA};
        vecs[1] = '{req: 2'b11, a0: 3'd0, a1: 3'd3, exp_ack: 2'b01, exp_gid: 2'd0, exp_data: 17'h00005};
        vecs[2] = '{req: 2'b11, a0: 3'd6, a1: 3'd5, exp_ack: 2'b10, exp_gid: 2'd1, exp_data: 17'h1FFFA};
        vecs[3] = '{req: 2'b10, a0: 3'd0, a1: 3'd4, exp_ack: 2'b10, exp_gid: 2'd1, exp_data: 17'h00005};
        vecs[4] = '{req: 2'b01, a0: 3'd1, a1: 3'd0, exp_ack: 2'b01, exp_gid: 2'd0, exp_data: 17'h1FFFA};
        vecs[5] = '{req: 2'b11, a0: 3'd3, a1: 3'd2, exp_ack: 2'b10, exp_gid: 2'd1, exp_data: 17'h00005};
        vecs[6] = '{req: 2'b01, a0: 3'd7, a1: 3'd0, exp_ack: 2'b01, exp_gid: 2'd0, exp_data: 17'h1FFFA};

        // Reset state, then 100 idle cycles.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ack",      32'(ack_a), 32'd0);
        check("rst_rd_data",  32'(rd_data_a), 32'd0);
        check("rst_grant_id", 32'(grant_id_a), 32'd0);
        check("rst_busy",     32'(busy_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_activity", 32'(activity_a), 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (busy_a || ack_a != '0) busy_cnt++;
        end
        check("idle_busy_cycles", 32'(busy_cnt), 32'd0);

        // Single request, addr 2: mem_addr timing, ack timing, busy length.
        req_a = 2'b01; req_addr_a = {3'd0, 3'd2};
        busy_cnt = 0; ack_cyc = 0; g_ack = '0; g_data = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("single_mem_addr", 32'(mem_addr_a), 32'd2);
            if (busy_a) busy_cnt++;
            if (ack_a != '0 && ack_cyc == 0) begin
                ack_cyc = c; g_ack = ack_a; g_data = rd_data_a; req_a = '0;
            end
        end
        check("single_ack_cycle", 32'(ack_cyc), 32'd3);
        check("single_ack",       32'(g_ack), 32'h1);
        check("single_rd_data",   32'(g_data), 32'h00005);
        check("single_busy_len",  32'(busy_cnt), 32'd3);
        check("single_hold_data", 32'(rd_data_a), 32'h00005);

        // Table of single transactions; the round-robin pointer carries across rows.
        foreach (vecs[i]) begin
            run_txn(0, vecs[i].req, vecs[i].a0, vecs[i].a1, lat, g_ack, g_gid, g_data, g_act);
            check($sformatf("v%0d_ack", i),      32'(g_ack), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_grant", i),    32'(g_gid), 32'(vecs[i].exp_gid));
            check($sformatf("v%0d_data", i),     32'(g_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_latency", i),  32'(lat), 32'd3);
            check($sformatf("v%0d_activity", i), 32'(g_act), 32'd1);
        end

        // Both requesters held; each drops on its ack and re-raises in the next IDLE.
        do_reset();
        req_a = 2'b11; req_addr_a = {3'd4, 3'd1};
        n_ack = 0; last_cyc = 0; cyc = 0; pend = '0;
        while (n_ack < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            req_a = req_a | pend;
            pend  = '0;
            if (ack_a != '0) begin
                check($sformatf("alt%0d_ack", n_ack),   32'(ack_a), (n_ack % 2 == 0) ? 32'h1 : 32'h2);
                check($sformatf("alt%0d_grant", n_ack), 32'(grant_id_a), (n_ack % 2 == 0) ? 32'd0 : 32'd1);
                check($sformatf("alt%0d_data", n_ack),  32'(rd_data_a), (n_ack % 2 == 0) ? 32'h1FFFA : 32'h00005);
                check($sformatf("alt%0d_cycle", n_ack), 32'(cyc - last_cyc), (n_ack == 0) ? 32'd3 : 32'd4);
                last_cyc = cyc;
                pend  = ack_a;
                req_a = req_a & ~ack_a;
                n_ack++;
            end
        end
        check("alt_ack_count", 32'(n_ack), 32'd4);
        req_a = '0;
        @(posedge clk); #1;

        // req[1] dropped during WAIT: the read still completes exactly once.
        req_a = 2'b10; req_addr_a = {3'd5, 3'd0};
        @(posedge clk); #1;
        req_a = '0;
        ack1_cnt = 0; ack0_cnt = 0; g_data = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ack_a[1]) begin ack1_cnt++; g_data = rd_data_a; end
            if (ack_a[0]) ack0_cnt++;
        end
        check("drop_ack1_count", 32'(ack1_cnt), 32'd1);
        check("drop_ack0_count", 32'(ack0_cnt), 32'd0);
        check("drop_data",       32'(g_data), 32'h1FFFA);
        check("drop_busy_end",   32'(busy_a), 32'd0);

        // Reset pulsed during WAIT: immediate clear, no ack, then held req[1] is served.
        req_a = 2'b10; req_addr_a = {3'd3, 3'd0};
        @(posedge clk); #1;
        check("rstw_in_wait", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy",     32'(busy_a), 32'd0);
        check("rstw_grant_id", 32'(grant_id_a), 32'd0);
        check("rstw_rd_data",  32'(rd_data_a), 32'd0);
        check("rstw_mem_addr", 32'(mem_addr_a), 32'd0);
        ack1_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ack_a != '0) ack1_cnt++;
        end
        check("rstw_no_ack", 32'(ack1_cnt), 32'd0);
        rst_n = 1'b1;
        run_txn(0, 2'b10, 3'd0, 3'd3, lat, g_ack, g_gid, g_data, g_act);
        check("rstw_after_ack",     32'(g_ack), 32'h2);
        check("rstw_after_grant",   32'(g_gid), 32'd1);
        check("rstw_after_data",    32'(g_data), 32'h1FFFA);
        check("rstw_after_latency", 32'(lat), 32'd3);

        // RD_LAT=3 instance: latency and data for every address.
        for (int a = 0; a < 8; a++) begin
            av = AW'(a);
            r  = av[1] ? 2'b10 : 2'b01;
            run_txn(1, r, av, av, lat, g_ack, g_gid, g_data, g_act);
            check($sformatf("lat3_a%0d_latency", a), 32'(lat), 32'd5);
            check($sformatf("lat3_a%0d_ack", a),     32'(g_ack), 32'(r));
            check($sformatf("lat3_a%0d_data", a),    32'(g_data), 32'(mem_fn(av)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
